// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter/sequencer in front of the single-ported
// data memory. Grants one of port A (CPU load/store) or port B (debug/DMA),
// issues a one-cycle command pulse, tracks the memory's clk_stall handshake,
// latches read data per port and aborts hung transactions with a watchdog.
module data_mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic        a_memread,
  input  logic        a_memwrite,
  input  logic [3:0]  a_sign_mask,
  output logic        a_done,
  output logic        a_err,
  output logic [31:0] a_rdata,
  output logic        a_stall,

  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic        b_memread,
  input  logic        b_memwrite,
  input  logic [3:0]  b_sign_mask,
  output logic        b_done,
  output logic        b_err,
  output logic [31:0] b_rdata,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  port_t       last;
  port_t       owner;
  logic [7:0]  wd_cnt;
  logic        seen;
  logic        op_read;
  logic        err_q;

  logic        pending;
  logic        grant_b;
  logic        g_read;
  logic        g_write;
  logic        wait_done;
  logic        wait_timeout;

  // Arbitration: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    pending      = a_req | b_req;
    grant_b      = b_req & (~a_req | (last == PORT_A));
    g_read       = grant_b ? b_memread  : a_memread;
    g_write      = grant_b ? b_memwrite : a_memwrite;
    wait_done    = seen & ~mem_clk_stall;
    wait_timeout = (wd_cnt == WD_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  // A no-op request spends its ISSUE cycle with no command bit raised and then
  // goes straight to RESP, so its done lands two cycles after the request.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (pending) state_nx = ISSUE;
      ISSUE: state_nx = (mem_memread | mem_memwrite) ? WAIT : RESP;
      WAIT:  if (wait_done || wait_timeout) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transaction datapath: grant capture, command pulse, watchdog, read latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last           <= PORT_B;
      owner          <= PORT_A;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      op_read        <= 1'b0;
      err_q          <= 1'b0;
      wd_cnt         <= '0;
      seen           <= 1'b0;
      a_rdata        <= '0;
      b_rdata        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending) begin
            owner          <= grant_b ? PORT_B : PORT_A;
            last           <= grant_b ? PORT_B : PORT_A;
            mem_addr       <= grant_b ? b_addr      : a_addr;
            mem_write_data <= grant_b ? b_wdata     : a_wdata;
            mem_sign_mask  <= grant_b ? b_sign_mask : a_sign_mask;
            mem_memwrite   <= g_write;
            mem_memread    <= g_read & ~g_write;
            op_read        <= g_read & ~g_write;
            err_q          <= 1'b0;
          end
        end
        ISSUE: begin
          mem_memread  <= 1'b0;
          mem_memwrite <= 1'b0;
          wd_cnt       <= '0;
          seen         <= 1'b0;
        end
        WAIT: begin
          if (mem_clk_stall) seen <= 1'b1;
          wd_cnt <= wd_cnt + 8'd1;
          if (wait_done) begin
            err_q <= 1'b0;
            if (op_read) begin
              if (owner == PORT_A) a_rdata <= mem_read_data;
              else                 b_rdata <= mem_read_data;
            end
          end else if (wait_timeout) begin
            err_q <= 1'b1;
            if (owner == PORT_A) a_rdata <= '0;
            else                 b_rdata <= '0;
          end
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Completion outputs are decoded from the RESP state and the owner.
  always_comb begin
    a_done  = (state == RESP) && (owner == PORT_A);
    b_done  = (state == RESP) && (owner == PORT_B);
    a_err   = a_done & err_q;
    b_err   = b_done & err_q;
    a_stall = a_req & ~a_done;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a small behavioural memory.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_req = 1'b0, b_req = 1'b0;
  logic [31:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic        a_memread = 1'b0, b_memread = 1'b0;
  logic        a_memwrite = 1'b0, b_memwrite = 1'b0;
  logic [3:0]  a_sign_mask = '0, b_sign_mask = '0;
  logic        a_done, b_done, a_err, b_err, a_stall;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread, mem_memwrite;
  logic [31:0] mem_read_data = '0;
  logic        mem_clk_stall = 1'b0;

  logic [31:0] led = '0;
  logic        force_stall = 1'b0;
  int unsigned stall_len = 1;
  int unsigned stall_left = 0;

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_memread(a_memread), .a_memwrite(a_memwrite), .a_sign_mask(a_sign_mask),
    .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata), .a_stall(a_stall),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_memread(b_memread), .b_memwrite(b_memwrite), .b_sign_mask(b_sign_mask),
    .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_1004: return 32'hDEAD_BEEF;
      32'h0000_1008: return 32'hCAFE_F00D;
      default:       return addr ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory model: a command raises clk_stall for stall_len cycles starting the
  // cycle after the pulse; reads present data during the stall.
  always @(posedge clk) begin
    if (force_stall) begin
      mem_clk_stall <= 1'b1;
    end else if (mem_memread || mem_memwrite) begin
      mem_clk_stall <= 1'b1;
      stall_left    <= stall_len - 1;
      if (mem_memwrite) begin
        if (mem_addr == 32'h0000_2000) led <= mem_write_data;
      end else begin
        mem_read_data <= mem_word(mem_addr);
      end
    end else if (stall_left != 0) begin
      stall_left <= stall_left - 1;
    end else begin
      mem_clk_stall <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    a_req = 1'b0; a_memread = 1'b0; a_memwrite = 1'b0;
    a_addr = '0; a_wdata = '0; a_sign_mask = '0;
  endtask

  task automatic clear_b();
    b_req = 1'b0; b_memread = 1'b0; b_memwrite = 1'b0;
    b_addr = '0; b_wdata = '0; b_sign_mask = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_a();
    clear_b();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_done, b_done, a_err, b_err, mem_memread, mem_memwrite, a_stall} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {a_done, b_done, a_err, b_err, mem_memread, mem_memwrite, a_stall});
    end
    checks++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got a=%h b=%h want 0", a_rdata, b_rdata);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_write_data !== 32'h0 || mem_sign_mask !== 4'h0) begin
      errors++;
      $display("FAIL reset_mem_fields got %h %h %h want 0", mem_addr, mem_write_data, mem_sign_mask);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_port_a_read();
    tick();
    a_req = 1'b1; a_memread = 1'b1; a_addr = 32'h1004; a_sign_mask = 4'b0110;
    #1;
    checks++;
    if (a_stall !== 1'b1) begin
      errors++;
      $display("FAIL a_read_stall_c0 got %b want 1", a_stall);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (mem_memread !== (c == 1) || mem_memwrite !== 1'b0) begin
        errors++;
        $display("FAIL a_read_pulse c%0d got rd=%b wr=%b want rd=%b wr=0", c, mem_memread, mem_memwrite, (c == 1));
      end
      checks++;
      if (a_done !== (c == 4)) begin
        errors++;
        $display("FAIL a_read_done c%0d got %b want %b", c, a_done, (c == 4));
      end
      checks++;
      if (a_stall !== (c < 4)) begin
        errors++;
        $display("FAIL a_read_stall c%0d got %b want %b", c, a_stall, (c < 4));
      end
      checks++;
      if (mem_addr !== 32'h1004 || mem_sign_mask !== 4'b0110) begin
        errors++;
        $display("FAIL a_read_fields c%0d got %h/%b want 00001004/0110", c, mem_addr, mem_sign_mask);
      end
    end
    checks++;
    if (a_rdata !== 32'hDEAD_BEEF || a_err !== 1'b0) begin
      errors++;
      $display("FAIL a_read_data got %h err=%b want deadbeef err=0", a_rdata, a_err);
    end
    clear_a();
  endtask

  task automatic test_simultaneous();
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    a_req = 1'b1; a_memwrite = 1'b1; a_addr = 32'h2000; a_wdata = 32'h11;
    b_req = 1'b1; b_memread = 1'b1; b_addr = 32'h1008; b_sign_mask = 4'b0110;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++;
      if (a_done !== (c == 4) || b_done !== (c == 9)) begin
        errors++;
        $display("FAIL simul_done c%0d got a=%b b=%b want a=%b b=%b", c, a_done, b_done, (c == 4), (c == 9));
      end
      if (c == 1) begin
        checks++;
        if (mem_memwrite !== 1'b1 || mem_addr !== 32'h2000 || mem_write_data !== 32'h11) begin
          errors++;
          $display("FAIL simul_a_issue got wr=%b addr=%h wd=%h want 1/2000/11", mem_memwrite, mem_addr, mem_write_data);
        end
      end
      if (c == 4) begin
        checks++;
        if (a_err !== 1'b0 || a_rdata !== 32'h0) begin
          errors++;
          $display("FAIL simul_a_resp got err=%b rdata=%h want 0/0", a_err, a_rdata);
        end
        clear_a();
      end
      if (c == 6) begin
        checks++;
        if (mem_memread !== 1'b1 || mem_addr !== 32'h1008) begin
          errors++;
          $display("FAIL simul_b_issue got rd=%b addr=%h want 1/1008", mem_memread, mem_addr);
        end
      end
      if (c == 9) begin
        checks++;
        if (b_rdata !== 32'hCAFE_F00D || b_err !== 1'b0) begin
          errors++;
          $display("FAIL simul_b_data got %h err=%b want cafef00d err=0", b_rdata, b_err);
        end
        clear_b();
      end
    end
    checks++;
    if (led !== 32'h11) begin
      errors++;
      $display("FAIL simul_led got %h want 11", led);
    end
  endtask

  task automatic test_contention();
    logic prev_cmd;
    logic cur_cmd;
    logic exp_a;
    logic exp_b;
    prev_cmd = 1'b0;
    tick();
    a_req = 1'b1; a_memread = 1'b1; a_addr = 32'h1004;
    b_req = 1'b1; b_memread = 1'b1; b_addr = 32'h1008;
    for (int c = 1; c <= 29; c++) begin
      tick();
      exp_a = (c % 5 == 4) && ((c / 5) % 2 == 0);
      exp_b = (c % 5 == 4) && ((c / 5) % 2 == 1);
      checks++;
      if (a_done !== exp_a || b_done !== exp_b) begin
        errors++;
        $display("FAIL contention_done c%0d got a=%b b=%b want a=%b b=%b", c, a_done, b_done, exp_a, exp_b);
      end
      cur_cmd = mem_memread | mem_memwrite;
      checks++;
      if ((prev_cmd & cur_cmd) !== 1'b0) begin
        errors++;
        $display("FAIL contention_pulse c%0d got back-to-back command want single-cycle", c);
      end
      prev_cmd = cur_cmd;
    end
    clear_a();
    clear_b();
    checks++;
    if (a_rdata !== 32'hDEAD_BEEF || b_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL contention_data got a=%h b=%h want deadbeef/cafef00d", a_rdata, b_rdata);
    end
  endtask

  task automatic test_stuck_stall();
    tick();
    force_stall = 1'b1;
    b_req = 1'b1; b_memread = 1'b1; b_addr = 32'h1008;
    for (int c = 1; c <= 18; c++) begin
      tick();
      checks++;
      if (b_done !== (c == 18) || a_done !== 1'b0) begin
        errors++;
        $display("FAIL stuck_done c%0d got b=%b a=%b want b=%b a=0", c, b_done, a_done, (c == 18));
      end
    end
    checks++;
    if (b_err !== 1'b1 || b_rdata !== 32'h0) begin
      errors++;
      $display("FAIL stuck_err got err=%b rdata=%h want 1/0", b_err, b_rdata);
    end
    clear_b();
    force_stall = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    tick();
    stall_len = 3;
    a_req = 1'b1; a_memread = 1'b1; a_addr = 32'h1004;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_rdata !== 32'h0 || {a_done, b_done, a_err, b_err, mem_memread, mem_memwrite} !== 6'b0) begin
      errors++;
      $display("FAIL midwait_reset_out got rdata=%h flags=%b want 0", a_rdata,
               {a_done, b_done, a_err, b_err, mem_memread, mem_memwrite});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_sign_mask !== 4'h0 || a_stall !== 1'b1) begin
      errors++;
      $display("FAIL midwait_reset_fields got addr=%h sm=%h stall=%b want 0/0/1", mem_addr, mem_sign_mask, a_stall);
    end
    clear_a();
    #1;
    checks++;
    if (a_stall !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset_stall got %b want 0", a_stall);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ((a_done | b_done) !== 1'b0) begin
        errors++;
        $display("FAIL midwait_no_done c%0d got a=%b b=%b want 0", c, a_done, b_done);
      end
    end
    stall_len = 1;
    a_req = 1'b1; a_memread = 1'b1; a_addr = 32'h1004;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (a_done !== (c == 4)) begin
        errors++;
        $display("FAIL midwait_retry_done c%0d got %b want %b", c, a_done, (c == 4));
      end
    end
    checks++;
    if (a_rdata !== 32'hDEAD_BEEF || a_err !== 1'b0) begin
      errors++;
      $display("FAIL midwait_retry_data got %h err=%b want deadbeef err=0", a_rdata, a_err);
    end
    clear_a();
  endtask

  task automatic test_conflict_noop();
    tick();
    b_req = 1'b1; b_memread = 1'b1; b_memwrite = 1'b1; b_addr = 32'h2000; b_wdata = 32'h55;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (mem_memwrite !== (c == 1) || mem_memread !== 1'b0) begin
        errors++;
        $display("FAIL conflict_pulse c%0d got wr=%b rd=%b want wr=%b rd=0", c, mem_memwrite, mem_memread, (c == 1));
      end
      checks++;
      if (b_done !== (c == 4)) begin
        errors++;
        $display("FAIL conflict_done c%0d got %b want %b", c, b_done, (c == 4));
      end
    end
    checks++;
    if (b_err !== 1'b0 || b_rdata !== 32'h0) begin
      errors++;
      $display("FAIL conflict_resp got err=%b rdata=%h want 0/0", b_err, b_rdata);
    end
    clear_b();
    tick();
    checks++;
    if (led !== 32'h55) begin
      errors++;
      $display("FAIL conflict_led got %h want 55", led);
    end
    a_req = 1'b1; a_addr = 32'h1234;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if ((mem_memread | mem_memwrite) !== 1'b0) begin
        errors++;
        $display("FAIL noop_pulse c%0d got rd=%b wr=%b want 0", c, mem_memread, mem_memwrite);
      end
      checks++;
      if (a_done !== (c == 2)) begin
        errors++;
        $display("FAIL noop_done c%0d got %b want %b", c, a_done, (c == 2));
      end
      if (c == 2) begin
        checks++;
        if (a_err !== 1'b0 || a_rdata !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL noop_resp got err=%b rdata=%h want 0/deadbeef", a_err, a_rdata);
        end
        clear_a();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_port_a_read();
    test_simultaneous();
    test_contention();
    test_stuck_stall();
    test_reset_mid_wait();
    test_conflict_noop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
